multiplier_unit: RTL and testbench

MULTIPLIER_UNIT -- requirements
Module: multiplier_unit

---
 rtl/multiplier_pkg.sv | 15 +
 rtl/mult_full_adder.sv | 18 +
 rtl/multiplier_unit.sv | 86 ++++++++
 tb/tb_multiplier_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multiplier_pkg : shared width constant and product-width helper     |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
package multiplier_pkg;

  localparam int c_default_width = 2;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_full_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_full_adder : one-bit full adder cell of the multiplier array   |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module mult_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/multiplier_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multiplier_unit : unsigned WIDTH x WIDTH AND-array multiplier       |
// | Macro MULTIPLIER_OREG_EN registers P/out_valid (latency 1).          |
// | Revision 1.0                                                        |
// +--------------------------------------------------------------------+
module multiplier_unit
  import multiplier_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             A,
  input  logic [WIDTH-1:0]             B,
  input  logic                         in_valid,
  output logic [prod_width(WIDTH)-1:0] P,
  output logic                         out_valid
);

  localparam int c_prod_w = prod_width(WIDTH);

  logic [WIDTH-1:0]    w_pp    [WIDTH];
  logic [WIDTH-1:0]    w_acc   [WIDTH];
  logic [WIDTH-1:0]    w_sum   [1:WIDTH-1];
  logic [WIDTH-1:0]    w_carry [1:WIDTH-1];
  logic [c_prod_w-1:0] w_prod;

  for (genvar r = 0; r < WIDTH; r++) begin : g_pp_row
    assign w_pp[r] = A & {WIDTH{B[r]}};
  end

  // Each row retires its LSB into the product and shifts the rest down.
  assign w_prod[0] = w_pp[0][0];
  assign w_acc[0]  = {1'b0, w_pp[0][WIDTH-1:1]};

  for (genvar r = 1; r < WIDTH; r++) begin : g_add_row
    for (genvar c = 0; c < WIDTH; c++) begin : g_cell
      logic w_cin;
      if (c == 0) begin : g_lsb
        assign w_cin = 1'b0;
      end else begin : g_chain
        assign w_cin = w_carry[r][c-1];
      end
      mult_full_adder u_fa (
        .a    (w_acc[r-1][c]),
        .b    (w_pp[r][c]),
        .cin  (w_cin),
        .s    (w_sum[r][c]),
        .cout (w_carry[r][c])
      );
    end
    assign w_prod[r] = w_sum[r][0];
    assign w_acc[r]  = {w_carry[r][WIDTH-1], w_sum[r][WIDTH-1:1]};
  end

  assign w_prod[c_prod_w-1:WIDTH] = w_acc[WIDTH-1];

`ifdef MULTIPLIER_OREG_EN
  logic [c_prod_w-1:0] r_p;
  logic                r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_p <= w_prod;
      end
    end
  end

  assign P         = r_p;
  assign out_valid = r_valid;
`else
  logic w_unused;
  assign w_unused  = &{1'b0, clk, rst_n};

  assign P         = w_prod;
  assign out_valid = in_valid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multiplier_unit.sv
`timescale 1ns/1ps
// Self-checking bench for multiplier_unit (WIDTH=2 and WIDTH=8 instances),
// covering both the combinational and MULTIPLIER_OREG_EN builds.
module tb_multiplier_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  a2, b2;
  logic        iv2;
  logic [3:0]  p2;
  logic        ov2;
  logic [7:0]  a8, b8;
  logic        iv8;
  logic [15:0] p8;
  logic        ov8;

  logic [3:0]  exp2_q [$];
  logic [15:0] exp8_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  multiplier_unit #(.WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .in_valid(iv2), .P(p2), .out_valid(ov2)
  );

  multiplier_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .in_valid(iv8), .P(p8), .out_valid(ov8)
  );

  // Registered build: result visible just after the next rising edge.
  task automatic settle();
`ifdef MULTIPLIER_OREG_EN
    @(posedge clk);
    #1;
`else
    #10;
`endif
  endtask

  task automatic drive2(input logic [1:0] a, input logic [1:0] b);
`ifdef MULTIPLIER_OREG_EN
    @(negedge clk);
`endif
    a2 = a; b2 = b; iv2 = 1'b1;
    exp2_q.push_back({2'b00, a} * {2'b00, b});
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b);
`ifdef MULTIPLIER_OREG_EN
    @(negedge clk);
`endif
    a8 = a; b8 = b; iv8 = 1'b1;
    exp8_q.push_back({8'h00, a} * {8'h00, b});
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (p2 !== 4'd0 || ov2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_w2: got P=%0d out_valid=%b, need P=0 out_valid=0", p2, ov2);
    end
    n_checks++;
    if (p8 !== 16'd0 || ov8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_w8: got P=%0d out_valid=%b, need P=0 out_valid=0", p8, ov8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [1:0] ta [4] = '{2'd3, 2'd1, 2'd3, 2'd2};
    logic [1:0] tb [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic [3:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive2(ta[i], tb[i]);
      settle();
      exp = (exp2_q.size() != 0) ? exp2_q.pop_front() : 4'hx;
      n_checks++;
      if (p2 !== exp || ov2 !== 1'b1) begin
        n_fail++;
        $display("FAIL directed %0dx%0d: got P=%0d ov=%b, need P=%0d ov=1", ta[i], tb[i], p2, ov2, exp);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] exp;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        drive2(2'(a), 2'(b));
        settle();
        exp = (exp2_q.size() != 0) ? exp2_q.pop_front() : 4'hx;
        n_checks++;
        if (p2 !== exp || ov2 !== 1'b1) begin
          n_fail++;
          $display("FAIL exhaustive %0dx%0d: got P=%0d ov=%b, need P=%0d ov=1", a, b, p2, ov2, exp);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [3:0] exp;
    drive2(2'd2, 2'd2);
    settle();
    exp = (exp2_q.size() != 0) ? exp2_q.pop_front() : 4'hx;
    n_checks++;
    if (p2 !== exp || ov2 !== 1'b1) begin
      n_fail++;
      $display("FAIL load_2x2: got P=%0d ov=%b, need P=%0d ov=1", p2, ov2, exp);
    end
`ifdef MULTIPLIER_OREG_EN
    @(negedge clk);
    exp = 4'd4;
`else
    exp = 4'd9;
`endif
    a2 = 2'd3; b2 = 2'd3; iv2 = 1'b0;
    settle();
    n_checks++;
    if (p2 !== exp || ov2 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_cycle: got P=%0d ov=%b, need P=%0d ov=0", p2, ov2, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ta [3] = '{2'd3, 2'd1, 2'd3};
    logic [1:0] tb [3] = '{2'd2, 2'd1, 2'd3};
    logic [3:0] exp;
    for (int i = 0; i < 3; i++) begin
      drive2(ta[i], tb[i]);
      settle();
      exp = (exp2_q.size() != 0) ? exp2_q.pop_front() : 4'hx;
      n_checks++;
      if (p2 !== exp || ov2 !== 1'b1) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got P=%0d ov=%b, need P=%0d ov=1", i, p2, ov2, exp);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [3:0] exp;
    drive2(2'd3, 2'd3);
    settle();
    exp = (exp2_q.size() != 0) ? exp2_q.pop_front() : 4'hx;
    n_checks++;
    if (p2 !== exp || ov2 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got P=%0d ov=%b, need P=%0d ov=1", p2, ov2, exp);
    end
`ifdef MULTIPLIER_OREG_EN
    #2;
    rst_n = 1'b0;
    a2 = 2'd2; b2 = 2'd2; iv2 = 1'b1;
    #1;
    n_checks++;
    if (p2 !== 4'd0 || ov2 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got P=%0d ov=%b, need P=0 ov=0", p2, ov2);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (p2 !== 4'd0 || ov2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: got P=%0d ov=%b, need P=0 ov=0", p2, ov2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    iv2 = 1'b0;
    drive2(2'd2, 2'd3);
    settle();
    exp = (exp2_q.size() != 0) ? exp2_q.pop_front() : 4'hx;
    n_checks++;
    if (p2 !== exp || ov2 !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset: got P=%0d ov=%b, need P=%0d ov=1", p2, ov2, exp);
    end
`else
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (p2 !== 4'd9 || ov2 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ignored: got P=%0d ov=%b, need P=9 ov=1", p2, ov2);
    end
    rst_n = 1'b1;
`endif
  endtask

  task automatic test_wide();
    logic [7:0]  ta [8];
    logic [7:0]  tb [8];
    logic [15:0] exp;
    ta[0] = 8'd255; tb[0] = 8'd255;
    ta[1] = 8'd128; tb[1] = 8'd2;
    ta[2] = 8'd0;   tb[2] = 8'd77;
    ta[3] = 8'd1;   tb[3] = 8'd200;
    for (int i = 4; i < 8; i++) begin
      ta[i] = 8'($urandom_range(0, 255));
      tb[i] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 8; i++) begin
      drive8(ta[i], tb[i]);
      settle();
      exp = (exp8_q.size() != 0) ? exp8_q.pop_front() : 16'hxxxx;
      n_checks++;
      if (p8 !== exp || ov8 !== 1'b1) begin
        n_fail++;
        $display("FAIL wide %0dx%0d: got P=%0d ov=%b, need P=%0d ov=1", ta[i], tb[i], p8, ov8, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a2 = '0; b2 = '0; iv2 = 1'b0;
    a8 = '0; b8 = '0; iv8 = 1'b0;
    test_reset();
    test_directed();
    test_exhaustive();
    test_hold();
    test_back_to_back();
    test_midstream_reset();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
